// File: rtl/jump_pkg.sv
// Shared definitions for the player jump sequencer: state encoding and
// default timing/geometry constants.
package jump_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    FALL   = 2'b10,
    HANG   = 2'b11
  } jump_state_e;

  localparam int TICK_DIV_DEF   = 1_000_000;
  localparam int H_MAX_DEF      = 200;
  localparam int H_STEP_DEF     = 50;
  localparam int HANG_TICKS_DEF = 4;
  localparam int HW_DEF         = 9;

endpackage

// File: rtl/btn_sync_edge.sv
// Button front end: two-flop synchroniser for an asynchronous input followed
// by a registered rising-edge detector. Shared by all game buttons.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic sync1, sync2, sync2_d;

  // Synchronise, remember the previous synchronised level, emit a one-cycle pulse on 0->1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      sync2_d <= sync2;
      pulse   <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/jump_ctrl.sv
// Vertical jump sequencer: button front end, frame tick and the
// ground/rise/apex/fall state machine owning the height register.
// Optional apex hold is built only when APEX_HOLD_EN is defined.
//
// state  | meaning
// -------+----------------------------------------------------------
// GROUND | h = 0, waiting for a press
// RISE   | h climbs by H_STEP per tick up to H_MAX
// HANG   | h held at H_MAX for HANG_TICKS ticks (APEX_HOLD_EN only)
// FALL   | h drops by H_STEP per tick, land pulse on reaching 0
module jump_ctrl
  import jump_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int H_MAX      = H_MAX_DEF,
  parameter int H_STEP     = H_STEP_DEF,
  parameter int HANG_TICKS = HANG_TICKS_DEF,
  parameter int HW         = HW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_jump,
  input  logic          pause,
  input  logic          game_over,
  output logic [HW-1:0] h,
  output logic [1:0]    jumpstate,
  output logic          busy,
  output logic          land
);

  localparam logic [1:0] S_GROUND = GROUND;
  localparam logic [1:0] S_RISE   = RISE;
  localparam logic [1:0] S_FALL   = FALL;

  localparam int            TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HMAX      = HW'(H_MAX);
  localparam logic [HW-1:0] HSTEP     = HW'(H_STEP);
  localparam logic [HW-1:0] HRISE_LIM = HW'(H_MAX - H_STEP);

`ifdef APEX_HOLD_EN
  localparam logic [1:0]    S_HANG    = HANG;
  localparam int            CW        = (HANG_TICKS > 2) ? $clog2(HANG_TICKS) : 1;
  localparam logic [CW-1:0] HANG_LAST = CW'(HANG_TICKS - 1);
  localparam bit            HANG_BAD  = (HANG_TICKS < 1);
  logic [CW-1:0] hcnt, hcnt_nxt;
`else
  localparam bit            HANG_BAD  = (HANG_TICKS < 0);
`endif

  localparam bit CFG_BAD = (TICK_DIV < 2) || (H_STEP < 1) || (H_MAX < 1) ||
                           ((H_MAX % H_STEP) != 0) ||
                           ((1 << HW) <= (H_MAX + H_STEP)) || HANG_BAD;

  if (CFG_BAD) begin : g_cfg_bad
    $error("jump_ctrl: illegal parameter combination");
  end

  logic          press, press_ok, tick;
  logic [TW-1:0] tcnt;
  logic [1:0]    state, state_nxt;
  logic [HW-1:0] h_nxt;
  logic          land_nxt;

  btn_sync_edge u_btn (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_jump),
    .pulse (press)
  );

  assign press_ok = press & ~pause;
  assign tick     = (tcnt == '0);

  // Frame tick down-counter; reload value puts the first tick TICK_DIV cycles after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        tcnt <= TICK_LAST;
    else if (!pause) tcnt <= tick ? TICK_LAST : tcnt - 1'b1;
  end

  // Next-state and height update; game_over wins over pause, pause over press/tick
  always_comb begin
    state_nxt = state;
    h_nxt     = h;
    land_nxt  = 1'b0;
`ifdef APEX_HOLD_EN
    hcnt_nxt  = hcnt;
`endif
    if (game_over) begin
      state_nxt = S_GROUND;
      h_nxt     = '0;
`ifdef APEX_HOLD_EN
      hcnt_nxt  = '0;
`endif
    end else if (!pause) begin
      case (state)
        S_GROUND: begin
          // a tick coinciding with the press is swallowed: h stays 0
          if (press_ok) state_nxt = S_RISE;
        end
        S_RISE: begin
          if (tick) begin
            if (h >= HRISE_LIM) begin
              h_nxt = HMAX;
`ifdef APEX_HOLD_EN
              state_nxt = S_HANG;
              hcnt_nxt  = HANG_LAST;
`else
              state_nxt = S_FALL;
`endif
            end else begin
              h_nxt = h + HSTEP;
            end
          end
        end
`ifdef APEX_HOLD_EN
        S_HANG: begin
          if (tick) begin
            if (hcnt == '0) state_nxt = S_FALL;
            else            hcnt_nxt  = hcnt - 1'b1;
          end
        end
`endif
        S_FALL: begin
          if (tick) begin
            if (h <= HSTEP) begin
              h_nxt     = '0;
              state_nxt = S_GROUND;
              land_nxt  = 1'b1;
            end else begin
              h_nxt = h - HSTEP;
            end
          end
        end
        default: begin
          state_nxt = S_GROUND;
          h_nxt     = '0;
        end
      endcase
    end
  end

  // State, height and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_GROUND;
      h     <= '0;
      busy  <= 1'b0;
      land  <= 1'b0;
    end else begin
      state <= state_nxt;
      h     <= h_nxt;
      busy  <= (state_nxt != S_GROUND);
      land  <= land_nxt;
    end
  end

`ifdef APEX_HOLD_EN
  // Apex hold down-counter, loaded on entry to HANG
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hcnt <= '0;
    else     hcnt <= hcnt_nxt;
  end
`endif

  assign jumpstate = state;

endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl with TICK_DIV=4. Expected per-tick
// height/state/land triples are queued when a press is accepted and
// popped at each frame tick predicted by the bench's own tick model.
module tb_jump_ctrl;
  import jump_pkg::*;

  localparam int TD  = 4;
  localparam int HMX = 200;
  localparam int HST = 50;
  localparam int NUP = HMX / HST;
`ifdef APEX_HOLD_EN
  localparam int HT = 4;
`else
  localparam int HT = 0;
`endif
  localparam int NJ = 2 * NUP + HT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_jump = 1'b0;
  logic       pause = 1'b0;
  logic       game_over = 1'b0;
  logic [8:0] h;
  logic [1:0] jumpstate;
  logic       busy, land;

  jump_ctrl #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_jump  (btn_jump),
    .pause     (pause),
    .game_over (game_over),
    .h         (h),
    .jumpstate (jumpstate),
    .busy      (busy),
    .land      (land)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] h;
    logic [1:0] js;
    logic       land;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ph     = 0;
  logic pop_edge = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int hv, input logic [1:0] js, input logic ld);
    exp_t e;
    e.h    = 9'(hv);
    e.js   = js;
    e.land = ld;
    sb.push_back(e);
  endtask

  // Expected trajectory of one complete jump, one entry per tick
  task automatic push_jump();
    for (int k = 1; k <= NUP; k++)
      push_exp(k * HST, (k < NUP) ? RISE : ((HT > 0) ? HANG : FALL), 1'b0);
    for (int k = 1; k <= HT; k++)
      push_exp(HMX, (k < HT) ? HANG : FALL, 1'b0);
    for (int k = NUP - 1; k >= 0; k--)
      push_exp(k * HST, (k > 0) ? FALL : GROUND, (k == 0));
  endtask

  // Bench tick model: tick when phase is TD-1, frozen under pause
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph       <= 0;
      pop_edge <= 1'b0;
    end else begin
      pop_edge <= (ph == TD - 1) && !pause && !game_over && (sb.size() > 0);
      if (!pause) ph <= (ph == TD - 1) ? 0 : ph + 1;
    end
  end

  // Compare DUT against the scoreboard after each tick edge
  always @(negedge clk) begin
    if (!rst) begin
      if (pop_edge && sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("tick_h", 32'(h), 32'(mon_e.h));
        chk("tick_js", 32'(jumpstate), 32'(mon_e.js));
        chk("tick_land", 32'(land), 32'(mon_e.land));
        chk("tick_busy", 32'(busy), 32'(mon_e.js != GROUND));
      end else begin
        chk("land_idle", 32'(land), 32'd0);
      end
    end
  end

  task automatic wait_sb(input int n, input string tag);
    int i;
    i = 0;
    while (sb.size() > n && i < 200) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk(tag, 32'(sb.size()), 32'(n));
  endtask

  // Press arrives 3 edges after btn rises; state changes on the 4th
  task automatic press_btn(input bit accept);
    btn_jump = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    if (accept) begin
      chk("press_js", 32'(jumpstate), 32'(RISE));
      chk("press_h", 32'(h), 32'd0);
      chk("press_busy", 32'(busy), 32'd1);
      push_jump();
    end
    btn_jump = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int i;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_h", 32'(h), 32'd0);
    chk("rst_js", 32'(jumpstate), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_land", 32'(land), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // full jump
    press_btn(1'b1);
    wait_sb(0, "jump1_done");
    repeat (6) @(negedge clk);
    chk("jump1_js", 32'(jumpstate), 32'd0);
    chk("jump1_h", 32'(h), 32'd0);
    chk("jump1_busy", 32'(busy), 32'd0);

    // presses while airborne are ignored and not queued
    @(negedge clk);
    press_btn(1'b1);
    wait_sb(NJ - 3, "air_at150");
    chk("air_h150", 32'(h), 32'd150);
    press_btn(1'b0);
    wait_sb(2, "air_at100f");
    chk("air_h100", 32'(h), 32'd100);
    press_btn(1'b0);
    wait_sb(0, "air_done");
    repeat (20) @(negedge clk);
    chk("air_no_rejump_js", 32'(jumpstate), 32'd0);
    chk("air_no_rejump_busy", 32'(busy), 32'd0);

    // pause for 10 cycles at h=100 in FALL
    @(negedge clk);
    press_btn(1'b1);
    wait_sb(2, "pause_at100");
    pause = 1'b1;
    repeat (10) @(negedge clk);
    chk("pause_h", 32'(h), 32'd100);
    chk("pause_js", 32'(jumpstate), 32'(FALL));
    pause = 1'b0;
    wait_sb(0, "pause_done");

    // game over at h=150 in RISE
    repeat (4) @(negedge clk);
    press_btn(1'b1);
    wait_sb(NJ - 3, "go_at150");
    game_over = 1'b1;
    @(posedge clk);
    #1;
    chk("go_h", 32'(h), 32'd0);
    chk("go_js", 32'(jumpstate), 32'd0);
    chk("go_busy", 32'(busy), 32'd0);
    chk("go_land", 32'(land), 32'd0);
    sb.delete();
    @(negedge clk);
    press_btn(1'b0);
    chk("go_press_js", 32'(jumpstate), 32'd0);
    repeat (5) @(negedge clk);
    game_over = 1'b0;
    repeat (8) @(negedge clk);
    chk("go_after_js", 32'(jumpstate), 32'd0);
    chk("go_after_h", 32'(h), 32'd0);

    // press landing on the tick cycle in GROUND
    i = 0;
    while (ph != 0 && i < 8) begin
      @(negedge clk);
      i++;
    end
    press_btn(1'b1);
    wait_sb(NJ - 1, "aligned_first");
    wait_sb(0, "aligned_done");

    // asynchronous reset mid-jump at h=100 in RISE
    repeat (4) @(negedge clk);
    press_btn(1'b1);
    wait_sb(NJ - 2, "rst_at100");
    chk("rst_pre_h", 32'(h), 32'd100);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_h", 32'(h), 32'd0);
    chk("rst_mid_js", 32'(jumpstate), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_land", 32'(land), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
